// File: rtl/apb_req_bridge_pkg.sv
// Shared definitions for the APB requester: the bridge state encoding and
// the default bus widths.
package apb_req_bridge_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/apb_req_bridge_if.sv
// Request/response handshake plus master-side APB bus of the requester.
// The master modport is the bridge; the slave modport is the command source and APB fabric.
interface apb_req_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic              PSEL;
    logic              PENABLE;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PWRITE, PWDATA, PSEL, PENABLE
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PWRITE, PWDATA, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_req_bridge_wait_timer.sv
// Saturating wait-state counter; expired flags the enabled cycle that reaches
// LIMIT so the caller can abort on that same edge. LIMIT=0 never expires.
module apb_req_bridge_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] SAT_VAL  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && count_reg != SAT_VAL) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (LIMIT > 0) && enable && (count_reg == LAST_VAL);
endmodule

// File: rtl/apb_req_bridge.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS transfer
// on the bus, valid/ready response out, with a wait-state timeout.
module apb_req_bridge
    import apb_req_bridge_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_req_bridge_if.master  bus
);
    state_t            state_reg;
    logic              req_ready_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;
    logic [ADDR_W-1:0] paddr_reg;
    logic              pwrite_reg;
    logic [DATA_W-1:0] pwdata_reg;
    logic              psel_reg;
    logic              penable_reg;
    logic              timer_clear;
    logic              timer_enable;
    logic              timer_expired;

    assign timer_clear  = (state_reg == SETUP);
    assign timer_enable = (state_reg == ACCESS) && !bus.PREADY;

    apb_req_bridge_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            paddr_reg     <= '0;
            pwrite_reg    <= 1'b0;
            pwdata_reg    <= '0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (bus.req_valid && req_ready_reg) begin
                        paddr_reg     <= bus.req_addr;
                        pwrite_reg    <= bus.req_write;
                        pwdata_reg    <= bus.req_wdata;
                        req_ready_reg <= 1'b0;
                        psel_reg      <= 1'b1;
                        state_reg     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over an expiry landing on the same edge.
                    if (bus.PREADY) begin
                        rsp_rdata_reg <= pwrite_reg ? '0 : bus.PRDATA;
                        rsp_err_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        state_reg     <= RESP;
                    end else if (timer_expired) begin
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.PADDR     = paddr_reg;
    assign bus.PWRITE    = pwrite_reg;
    assign bus.PWDATA    = pwdata_reg;
    assign bus.PSEL      = psel_reg;
    assign bus.PENABLE   = penable_reg;
endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed bench for apb_req_bridge: a simple APB slave model with a
// programmable wait count, cycle-exact checks sampled on the falling edge.
module tb_apb_req_bridge;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   wait_n;
    int   acc_cnt;
    logic [31:0] rd_val;

    apb_req_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_req_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: ready once wait_n not-ready ACCESS cycles have elapsed.
    always @(posedge clk) begin
        if (bus.PSEL && bus.PENABLE && !bus.PREADY)
            acc_cnt <= acc_cnt + 1;
        else if (!bus.PENABLE)
            acc_cnt <= 0;
    end
    assign bus.PREADY = bus.PSEL && bus.PENABLE && (acc_cnt >= wait_n);
    assign bus.PRDATA = rd_val;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one transfer starting at a falling edge with the bridge idle.
    task automatic run_xfer(input string name, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waits, input logic [31:0] slave_data,
                            input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                            input int stall);
        int cyc;
        wait_n = waits;
        rd_val = slave_data;
        check_eq({name, "_req_ready_idle"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        cyc = 1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h0;
        check_eq({name, "_setup_psel"}, 64'(bus.PSEL), 64'd1);
        check_eq({name, "_setup_penable"}, 64'(bus.PENABLE), 64'd0);
        check_eq({name, "_setup_pwrite"}, 64'(bus.PWRITE), 64'(wr));
        check_eq({name, "_setup_pwdata"}, 64'(bus.PWDATA), 64'(wdata));
        check_eq({name, "_req_ready_busy"}, 64'(bus.req_ready), 64'd0);
        while (!bus.rsp_valid && cyc < 40) begin
            check_eq({name, "_paddr_hold"}, 64'(bus.PADDR), 64'(addr));
            @(negedge clk);
            cyc++;
            if (!bus.rsp_valid) begin
                check_eq({name, "_access_psel"}, 64'(bus.PSEL), 64'd1);
                check_eq({name, "_access_penable"}, 64'(bus.PENABLE), 64'd1);
            end
        end
        check_eq({name, "_rsp_latency"}, 64'(cyc), 64'(exp_lat));
        check_eq({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
        check_eq({name, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rd));
        check_eq({name, "_rsp_err"}, 64'(bus.rsp_err), 64'(exp_err));
        check_eq({name, "_resp_psel"}, 64'(bus.PSEL), 64'd0);
        check_eq({name, "_resp_penable"}, 64'(bus.PENABLE), 64'd0);
        // A new command offered while the response waits must not start.
        for (int s = 0; s < stall; s++) begin
            bus.req_valid = 1'b1;
            @(negedge clk);
            check_eq({name, "_stall_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
            check_eq({name, "_stall_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rd));
            check_eq({name, "_stall_req_ready"}, 64'(bus.req_ready), 64'd0);
            check_eq({name, "_stall_psel"}, 64'(bus.PSEL), 64'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_eq({name, "_rsp_done"}, 64'(bus.rsp_valid), 64'd0);
        check_eq({name, "_req_ready_back"}, 64'(bus.req_ready), 64'd1);
        check_eq({name, "_paddr_kept"}, 64'(bus.PADDR), 64'(addr));
        $display("xfer %s wr=%0d addr=%08h lat=%0d rdata=%08h err=%0d", name, wr, addr, cyc,
                 exp_rd, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        wait_n = 0;
        rd_val = 32'h0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_psel", 64'(bus.PSEL), 64'd0);
        check_eq("rst_penable", 64'(bus.PENABLE), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_paddr", 64'(bus.PADDR), 64'd0);
        check_eq("rst_pwdata", 64'(bus.PWDATA), 64'd0);
        check_eq("rst_pwrite", 64'(bus.PWRITE), 64'd0);
        check_eq("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check_eq("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_eq("post_rst_req_ready_low", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check_eq("post_rst_req_ready_high", 64'(bus.req_ready), 64'd1);

        run_xfer("wr_zero_wait", 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF,
                 32'h0, 1'b0, 3, 0);
        run_xfer("rd_3_wait", 1'b0, 32'h0000_0010, 32'h0, 3, 32'h1234_5678,
                 32'h1234_5678, 1'b0, 6, 0);
        run_xfer("rd_timeout", 1'b0, 32'h0000_0020, 32'h0, 1000, 32'hCAFE_F00D,
                 32'h0, 1'b1, 18, 0);
        run_xfer("rd_stall", 1'b0, 32'h0000_0030, 32'h0, 1, 32'hA5A5_0F0F,
                 32'hA5A5_0F0F, 1'b0, 4, 5);
        run_xfer("wr_after_stall", 1'b1, 32'h0000_0034, 32'h0BAD_CAFE, 0, 32'h1111_2222,
                 32'h0, 1'b0, 3, 0);
        run_xfer("rd_ready_at_limit", 1'b0, 32'h0000_0040, 32'h0, 15, 32'h5555_AAAA,
                 32'h5555_AAAA, 1'b0, 18, 0);

        // Reset asserted in the middle of an ACCESS phase.
        wait_n = 1000;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_0050;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_in_access", 64'(bus.PENABLE), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_psel", 64'(bus.PSEL), 64'd0);
        check_eq("mid_rst_penable", 64'(bus.PENABLE), 64'd0);
        check_eq("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("mid_rst_release_ready_low", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check_eq("mid_rst_release_ready_high", 64'(bus.req_ready), 64'd1);
        $display("xfer mid_reset addr=00000050 aborted");
        run_xfer("rd_after_reset", 1'b0, 32'h0000_0060, 32'h0, 2, 32'h7777_8888,
                 32'h7777_8888, 1'b0, 5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_req_bridge.md
# apb_req_bridge

Upstream APB requester for the two-slave APB fabric. Accepts single read/write commands on a valid/ready request port, runs each as a compliant APB SETUP/ACCESS transfer on the shared master-side bus, and returns read data and status on a valid/ready response port. A wait-state timeout converts a slave that never asserts PREADY into an error response instead of a hung bus.

## Interface
- ADDR_W, 32, request address / PADDR width
- DATA_W, 32, PWDATA/PRDATA/response data width
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY=0 before abort; 0 disables timeout
- PCLK  in  1  bus clock, all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  command present
- req_ready  out  1  bridge can accept a command
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  1 = transfer timed out
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PSEL  out  1  APB select (decoded downstream per slave)
- PENABLE  out  1  APB access phase
- PRDATA  in  DATA_W  muxed slave read data
- PREADY  in  1  muxed slave ready

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready: register addr/write/wdata onto PADDR/PWRITE/PWDATA, -> SETUP.
- SETUP: PSEL=1, PENABLE=0, one cycle, -> ACCESS; wait counter cleared.
- ACCESS: PSEL=1, PENABLE=1. PREADY=1: capture PRDATA into rsp_rdata if read (0 if write), rsp_err=0, -> RESP. PREADY=0: counter+1; when counter reaches TIMEOUT_CYCLES (nonzero): rsp_rdata=0, rsp_err=1, -> RESP.
- RESP: PSEL=PENABLE=0, rsp_valid=1, rsp_rdata/rsp_err stable. On rsp_ready -> IDLE.
- PADDR/PWRITE/PWDATA hold from SETUP through end of ACCESS; unchanged in RESP/IDLE until next accept.
- Counter width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.
- Only one transfer outstanding; no request buffering.

## Timing
- Reset (async, immediate): state IDLE, req_ready=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. req_ready rises on first PCLK edge after PRESETn deasserts.
- req_ready and rsp_valid registered; no combinational path from req_* or rsp_ready to outputs.
- Zero-wait transfer: accept edge at cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 (PREADY=1) -> rsp_valid cycle 3.
- N wait states add N cycles in ACCESS.
- rsp_ready already high in first RESP cycle: one RESP cycle, req_ready=1 next cycle; peak throughput one transfer per 4 cycles.
- Timeout: rsp_valid asserted the cycle after the TIMEOUT_CYCLES-th PREADY=0 ACCESS cycle.
- PREADY=1 on the same edge the counter hits the limit: PREADY wins, normal response.
- Reset mid-transfer: PSEL/PENABLE drop immediately; in-flight command and pending response are discarded.

## Structure
- Shared apb_pkg: state enum (IDLE/SETUP/ACCESS/RESP), default ADDR_W/DATA_W constants.
- One sub-module: apb_wait_timer (clear, enable, limit parameter, expired output), instantiated once.

## Test plan
- Write 0x0000_0004, data 0xDEAD_BEEF, slave PREADY=1 -> PSEL cycle 1, PENABLE cycle 2, rsp_valid cycle 3, rsp_err=0, rsp_rdata=0.
- Read 0x0000_0010, slave 3 wait states returning 0x1234_5678 -> rsp_valid cycle 6, rsp_rdata=0x1234_5678, PADDR stable cycles 1-5.
- Read with PREADY held 0, TIMEOUT_CYCLES=16 -> 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSEL low in RESP.
- Back-to-back requests with rsp_ready stalled 5 cycles -> rsp_valid/rsp_rdata held 5 cycles, req_ready=0 throughout, next PSEL only after rsp_ready.
- PRESETn pulsed low during ACCESS -> PSEL/PENABLE/rsp_valid 0 immediately, req_ready=1 one edge after release, next transfer completes normally.
- PREADY=1 coincident with 16th wait cycle -> rsp_err=0, PRDATA captured.
